// File: rtl/expand_a_stream_if.sv
// rtl/expand_a_stream_if.sv - XOF squeeze and coefficient stream signals for expand_a_stream
interface expand_a_stream_if #(
    parameter int DATA_IN_BITS = 64,
    parameter int COEFF_WIDTH  = 24
) ();
    logic                    xof_start;
    logic [271:0]            xof_seed;
    logic                    xof_valid;
    logic [DATA_IN_BITS-1:0] xof_data;
    logic                    xof_ready;
    logic                    xof_stop;
    logic                    coeff_valid;
    logic                    coeff_ready;
    logic [COEFF_WIDTH-1:0]  coeff_data;
    logic [2:0]              coeff_row;
    logic [2:0]              coeff_col;
    logic [7:0]              coeff_idx;
    logic                    coeff_last;

    modport master (
        output xof_start, xof_seed, xof_ready, xof_stop,
        output coeff_valid, coeff_data, coeff_row, coeff_col, coeff_idx, coeff_last,
        input  xof_valid, xof_data, coeff_ready
    );

    modport slave (
        input  xof_start, xof_seed, xof_ready, xof_stop,
        input  coeff_valid, coeff_data, coeff_row, coeff_col, coeff_idx, coeff_last,
        output xof_valid, xof_data, coeff_ready
    );
endinterface

// File: rtl/expand_a_stream.sv
// rtl/expand_a_stream.sv - streaming ExpandA: per-entry SHAKE128 launch and rejection sampling
module expand_a_stream #(
    parameter int N            = 256,
    parameter int COEFF_WIDTH  = 24,
    parameter int Q            = 8380417,
    parameter int DATA_IN_BITS = 64,
    parameter int K_MAX        = 8,
    parameter int L_MAX        = 7
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            mode,
    input  logic [255:0]          rho,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    expand_a_stream_if.master     xs
);
    localparam int WB        = DATA_IN_BITS / 8;
    localparam int BUF_BYTES = WB + 2;
    localparam int CNT_W     = $clog2(BUF_BYTES + 1);
    localparam int IDX_W     = $clog2(N);
    localparam int RW        = $clog2(K_MAX);
    localparam int CW        = $clog2(L_MAX + 1);
    localparam logic [22:0] Q_W = 23'(Q);

    typedef enum logic [2:0] {S_IDLE, S_SEED, S_SAMPLE, S_NEXT, S_FIN} state_t;

    state_t                   state_q, state_d;
    logic [1:0]               mode_q, mode_d;
    logic [255:0]             rho_q, rho_d;
    logic [RW-1:0]            r_q, r_d;
    logic [CW-1:0]            s_q, s_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic                     full_q, full_d;
    logic [BUF_BYTES*8-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic                     cv_q, cv_d;
    logic [COEFF_WIDTH-1:0]   cdata_q, cdata_d;
    logic [RW-1:0]            crow_q, crow_d;
    logic [CW-1:0]            ccol_q, ccol_d;
    logic [IDX_W-1:0]         cidx_q, cidx_d;
    logic                     clast_q, clast_d;
    logic                     stop_q, stop_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic                     xof_ready_w;
    logic                     word_acc;
    logic                     pick;
    logic [22:0]              cand;
    logic [RW:0]              k_v, r_nx;
    logic [CW:0]              l_v, s_nx;
    logic [BUF_BYTES*8-1:0]   buf_v;
    logic [CNT_W-1:0]         cnt_v;

    assign xof_ready_w = (state_q == S_SAMPLE) && (cnt_q <= CNT_W'(2));
    assign word_acc    = xof_ready_w && xs.xof_valid;
    // The output register may be reloaded in the same cycle it is drained.
    assign pick        = (state_q == S_SAMPLE) && !full_q && (cnt_q >= CNT_W'(3))
                         && (!cv_q || xs.coeff_ready);
    assign cand        = buf_q[22:0];
    assign r_nx        = {1'b0, r_q} + 1'b1;
    assign s_nx        = {1'b0, s_q} + 1'b1;

    always_comb begin
        k_v = (RW+1)'(8);
        l_v = (CW+1)'(7);
        case (mode_q)
            2'd0:    begin k_v = (RW+1)'(4); l_v = (CW+1)'(4); end
            2'd1:    begin k_v = (RW+1)'(6); l_v = (CW+1)'(5); end
            default: begin k_v = (RW+1)'(8); l_v = (CW+1)'(7); end
        endcase
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rho_d   = rho_q;
        r_d     = r_q;
        s_d     = s_q;
        idx_d   = idx_q;
        full_d  = full_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        cv_d    = cv_q;
        cdata_d = cdata_q;
        crow_d  = crow_q;
        ccol_d  = ccol_q;
        cidx_d  = cidx_q;
        clast_d = clast_q;
        stop_d  = 1'b0;
        busy_d  = busy_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        buf_v   = buf_q;
        cnt_v   = cnt_q;

        if (cv_q && xs.coeff_ready) begin
            cv_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    rho_d  = rho;
                    busy_d = 1'b1;
                    r_d    = '0;
                    s_d    = '0;
                    state_d = (mode == 2'd3) ? S_FIN : S_SEED;
                end
            end
            S_SEED: begin
                buf_d   = '0;
                cnt_d   = '0;
                idx_d   = '0;
                full_d  = 1'b0;
                state_d = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (pick) begin
                    buf_v = buf_q >> 24;
                    cnt_v = cnt_q - CNT_W'(3);
                    if (cand < Q_W) begin
                        cv_d    = 1'b1;
                        cdata_d = {{(COEFF_WIDTH-23){1'b0}}, cand};
                        crow_d  = r_q;
                        ccol_d  = s_q;
                        cidx_d  = idx_q;
                        clast_d = (idx_q == IDX_W'(N-1)) && (r_nx == k_v) && (s_nx == l_v);
                        idx_d   = idx_q + 1'b1;
                        if (idx_q == IDX_W'(N-1)) begin
                            full_d = 1'b1;
                        end
                    end
                end
                // New word bytes land right after whatever survives this cycle's pick.
                if (word_acc) begin
                    for (int i = 0; i < WB; i++) begin
                        buf_v[(int'(cnt_v) + i) * 8 +: 8] = xs.xof_data[i*8 +: 8];
                    end
                    cnt_v = cnt_v + CNT_W'(WB);
                end
                buf_d = buf_v;
                cnt_d = cnt_v;
                if (full_q && cv_q && xs.coeff_ready) begin
                    stop_d  = 1'b1;
                    buf_d   = '0;
                    cnt_d   = '0;
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                state_d = S_SEED;
                if (s_nx == l_v) begin
                    s_d = '0;
                    r_d = r_nx[RW-1:0];
                    if (r_nx == k_v) begin
                        state_d = S_FIN;
                    end
                end else begin
                    s_d = s_nx[CW-1:0];
                end
            end
            S_FIN: begin
                done_d  = 1'b1;
                err_d   = (mode_q == 2'd3);
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            mode_q  <= '0;
            rho_q   <= '0;
            r_q     <= '0;
            s_q     <= '0;
            idx_q   <= '0;
            full_q  <= 1'b0;
            buf_q   <= '0;
            cnt_q   <= '0;
            cv_q    <= 1'b0;
            cdata_q <= '0;
            crow_q  <= '0;
            ccol_q  <= '0;
            cidx_q  <= '0;
            clast_q <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rho_q   <= rho_d;
            r_q     <= r_d;
            s_q     <= s_d;
            idx_q   <= idx_d;
            full_q  <= full_d;
            buf_q   <= buf_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            cdata_q <= cdata_d;
            crow_q  <= crow_d;
            ccol_q  <= ccol_d;
            cidx_q  <= cidx_d;
            clast_q <= clast_d;
            stop_q  <= stop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign xs.xof_start   = (state_q == S_SEED);
    assign xs.xof_seed    = {{(8-RW){1'b0}}, r_q, {(8-CW){1'b0}}, s_q, rho_q};
    assign xs.xof_ready   = xof_ready_w;
    assign xs.xof_stop    = stop_q;
    assign xs.coeff_valid = cv_q;
    assign xs.coeff_data  = cdata_q;
    assign xs.coeff_row   = crow_q;
    assign xs.coeff_col   = ccol_q;
    assign xs.coeff_idx   = cidx_q;
    assign xs.coeff_last  = clast_q;
endmodule

// File: doc/expand_a_stream.md
Name: expand_a_stream

Overview:
- Runtime-configurable, streaming successor of the ExpandA matrix generator for ML-DSA / Dilithium.
- Walks every matrix entry A[r][s] for the security level on `mode`. Launches one SHAKE128 instance per entry on an external Keccak core.
- Rejection-samples the squeezed bytes into coefficients mod Q. Streams them out tagged with row, column and index, under valid/ready backpressure.
- Replaces the flat K*L*N-wide matA bus with a stream feeding NTT and matrix-vector units.

Parameters:
N, 256, coefficients per polynomial
COEFF_WIDTH, 24, output coefficient width (>=23)
Q, 8380417, modulus; candidates >= Q rejected
DATA_IN_BITS, 64, XOF squeeze word width; multiple of 8, >=24
K_MAX, 8, largest row count supported
L_MAX, 7, largest column count supported

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; sampled only in IDLE
mode  in  2  0: K=4,L=4; 1: K=6,L=5; 2: K=8,L=7; 3: illegal
rho  in  256  public seed; captured on start
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse at end of run
err  out  1  one-cycle pulse with done when mode==3
xof_start  out  1  one-cycle pulse; xof_seed valid with it
xof_seed  out  272  {r[7:0], s[7:0], rho}; rho in bits [255:0], s byte 32, r byte 33
xof_valid  in  1  squeeze word valid
xof_data  in  DATA_IN_BITS  squeeze word; byte 0 = bits [7:0]
xof_ready  out  1  word accepted when xof_valid && xof_ready
xof_stop  out  1  one-cycle pulse; Keccak must drop the current instance
coeff_valid  out  1  coefficient valid
coeff_ready  in  1  downstream accept
coeff_data  out  COEFF_WIDTH  coefficient, zero-extended, < Q
coeff_row  out  3  r
coeff_col  out  3  s
coeff_idx  out  8  coefficient index 0..N-1
coeff_last  out  1  high on the final coefficient of the final entry

Behaviour:
- Reset: all outputs 0; FSM to IDLE; byte buffer emptied; counters cleared.
- Reset asserted mid-run aborts at once. No done pulse. No xof_stop (Keccak is reset by the same rst).
- FSM states: IDLE, SEED, SAMPLE, NEXT, FIN.
- IDLE: on start, latch mode and rho; busy=1.
  - mode==3: go to FIN with err.
  - otherwise r=0, s=0, go to SEED.
- SEED (1 cycle): pulse xof_start; xof_seed = {r,s,rho}; clear byte buffer and idx; go to SAMPLE.
- SAMPLE, byte buffer:
  - Capacity DATA_IN_BITS/8+2 bytes.
  - xof_ready = (count <= 2) && state==SAMPLE.
  - An accepted word appends its bytes in order, byte 0 first.
- SAMPLE, candidate pick:
  - Each cycle with count>=3 and the output register free (or freed this cycle by coeff_ready), consume 3 bytes b0,b1,b2.
  - Candidate t = b0 | b1<<8 | (b2 & 0x7F)<<16.
  - t < Q: load output register with t, r, s, idx; set coeff_valid; idx++.
  - t >= Q: discard, no output.
  - Throughput: one candidate per cycle.
- Output handshake:
  - coeff_valid stays high and all coeff_* stay stable until coeff_ready.
  - Back-to-back transfers every cycle are allowed.
- Entry complete: when the coefficient with idx==N-1 is loaded, stop consuming.
  - After it is accepted: pulse xof_stop, drop the leftover buffered bytes, go to NEXT.
- NEXT (1 cycle): s++.
  - s==L: s=0, r++.
  - r==K: go to FIN; otherwise go to SEED.
- coeff_last = 1 only when idx==N-1 && r==K-1 && s==L-1.
- FIN: pulse done (and err if illegal mode); busy=0; go to IDLE.
- start while busy: ignored.
- Simultaneous xof word accept and candidate consume in one cycle: count += DATA_IN_BITS/8 - 3.
- xof_valid with xof_ready low: word not taken; the Keccak side holds it.

Test Plan:
- Reset values: assert rst mid-SAMPLE with coeff_valid high -> next cycle all outputs 0, busy=0, no done. Then start with mode=0 -> full run completes normally.
- Sampler arithmetic: mode=0, first xof word bytes 01 00 80 | 00 E0 7F | 01 E0 7F | FF -> coefficients 0x000001 and 0x7FE000 emitted with idx 0,1. Candidate 0x7FE001 (=Q) rejected, idx stays 2.
- Word straddle: bytes 08..0F of word 0 plus bytes of word 1 -> candidate built from byte 6,7 of word 0 and byte 0 of word 1. xof_ready deasserts while count>2.
- Backpressure: hold coeff_ready=0 for 20 cycles -> coeff_* stable, xof_ready drops within 3 cycles, no bytes lost. Checked against a golden model with rho=0x1234567890abcdef repeated.
- Full sweep: mode=1 and mode=2 with a SHAKE128 reference model.
  - Exactly 30 (mode 1) and 56 (mode 2) xof_start pulses, seeds {r,s,rho} in row-major order.
  - 256 coefficients each; coeff_last only on (5,4,255) and (7,6,255); one done.
- Illegal mode: start with mode=3 -> no xof_start, done and err pulse 2 cycles after start, busy low afterwards.
